// File: rtl/seq_loader_pkg.sv
// Shared types and constants for the sequence loader: FSM state encoding,
// bus widths and the bit layout of a packed RAM word.
package seq_loader_pkg;

  localparam int unsigned FRAMES_PER_WORD = 3;
  localparam int unsigned ROM_AW          = 10;
  localparam int unsigned RAM_AW          = 7;
  localparam int unsigned RAM_DW          = 32;
  localparam int unsigned SEQ_W           = 6;

  // Packed word layout: three 10-bit frame slots plus a 2-bit valid count.
  localparam int unsigned SLOT_W    = 10;
  localparam int unsigned SLOT0_LSB = 0;
  localparam int unsigned SLOT1_LSB = 10;
  localparam int unsigned SLOT2_LSB = 20;
  localparam int unsigned COUNT_LSB = 30;
  localparam int unsigned COUNT_W   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StWrite,
    StDone
  } state_e;

  // Assemble one RAM word from the slot contents and the valid-slot count.
  function automatic logic [RAM_DW-1:0] pack_word(input logic [COUNT_W-1:0] cnt,
                                                  input logic [SLOT_W-1:0]  s0,
                                                  input logic [SLOT_W-1:0]  s1,
                                                  input logic [SLOT_W-1:0]  s2);
    logic [RAM_DW-1:0] w;
    w = '0;
    w[SLOT0_LSB +: SLOT_W]  = s0;
    w[SLOT1_LSB +: SLOT_W]  = s1;
    w[SLOT2_LSB +: SLOT_W]  = s2;
    w[COUNT_LSB +: COUNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/seq_loader_if.sv
// Request, ROM-read and RAM-write signals of the sequence loader.
// master: the loader itself; slave: the surrounding system (ROM/RAM/requester).
interface seq_loader_if;
  import seq_loader_pkg::*;

  logic                start;
  logic [SEQ_W-1:0]    seq_num;
  logic [ROM_AW-1:0]   rom_addr;
  logic [SLOT_W-1:0]   rom_q;
  logic [RAM_AW-1:0]   ram_wraddress;
  logic [RAM_DW-1:0]   ram_data;
  logic                ram_wren;
  logic                busy;
  logic                done;

  modport master (
    input  start, seq_num, rom_q,
    output rom_addr, ram_wraddress, ram_data, ram_wren, busy, done
  );

  modport slave (
    output start, seq_num, rom_q,
    input  rom_addr, ram_wraddress, ram_data, ram_wren, busy, done
  );

endinterface

// File: rtl/seq_loader_frame_packer.sv
// Collects up to three 10-bit frames into slot registers and presents the
// assembled RAM word. Cleared slots read as zero so partial words pad cleanly.
module frame_packer
  import seq_loader_pkg::*;
(
  input  logic               clk_50,
  input  logic               reset,
  input  logic               clear,
  input  logic               capture,
  input  logic [SLOT_W-1:0]  din,
  output logic [COUNT_W-1:0] count,
  output logic [RAM_DW-1:0]  word
);

  logic [SLOT_W-1:0]  slot_q [FRAMES_PER_WORD];
  logic [COUNT_W-1:0] count_q;

  // Slot storage and fill count; a capture lands in the slot selected by the count.
  always_ff @(posedge clk_50) begin
    if (reset || clear) begin
      count_q <= '0;
      for (int unsigned i = 0; i < FRAMES_PER_WORD; i++) begin
        slot_q[i] <= '0;
      end
    end else if (capture && (count_q < COUNT_W'(FRAMES_PER_WORD))) begin
      for (int unsigned i = 0; i < FRAMES_PER_WORD; i++) begin
        if (count_q == COUNT_W'(i)) begin
          slot_q[i] <= din;
        end
      end
      count_q <= count_q + 1'b1;
    end
  end

  // Word assembly from the current slot contents.
  always_comb begin
    count = count_q;
    word  = pack_word(count_q, slot_q[0], slot_q[1], slot_q[2]);
  end

endmodule

// File: rtl/seq_loader.sv
// Sequence loader: reads FRAMES_PER_SEQ 10-bit ROM frames for one sequence,
// packs them three per 32-bit word and writes the words to RAM from RAM_BASE.
// Optional feature macro: SEQ_LOADER_CHECKSUM_EN appends a modulo-1024 frame sum
// as one extra word after the last data word.
module seq_loader
  import seq_loader_pkg::*;
#(
  parameter int unsigned       FRAMES_PER_SEQ = 16,
  parameter logic [RAM_AW-1:0] RAM_BASE       = 7'd0
) (
  input  logic         clk_50,
  input  logic         reset,
  seq_loader_if.master bus
);

  localparam int unsigned FrameW = $clog2(FRAMES_PER_SEQ) + 1;
  typedef logic [FrameW-1:0] frame_t;
  localparam frame_t LastFrame = frame_t'(FRAMES_PER_SEQ - 1);
  localparam frame_t FrameEnd  = frame_t'(FRAMES_PER_SEQ);

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  frame_t              frame_q, frame_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0]   wraddr_q, wraddr_d;
  logic [15:0]         addr_full;

  logic                pk_clear;
  logic                pk_capture;
  logic [COUNT_W-1:0]  pk_count;
  logic [RAM_DW-1:0]   pk_word;
  logic [RAM_DW-1:0]   word_out;

`ifdef SEQ_LOADER_CHECKSUM_EN
  logic [SLOT_W-1:0]   sum_q, sum_d;
  logic                csum_phase_q, csum_phase_d;
`endif

  frame_packer u_packer (
    .clk_50  (clk_50),
    .reset   (reset),
    .clear   (pk_clear),
    .capture (pk_capture),
    .din     (bus.rom_q),
    .count   (pk_count),
    .word    (pk_word)
  );

  // Next-state, counter updates and packer control.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    frame_d    = frame_q;
    wraddr_d   = wraddr_q;
    pk_clear   = 1'b0;
    pk_capture = 1'b0;
`ifdef SEQ_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    csum_phase_d = csum_phase_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          seq_d    = bus.seq_num;
          frame_d  = '0;
          wraddr_d = RAM_BASE;
          pk_clear = 1'b1;
          state_d  = StFetch;
`ifdef SEQ_LOADER_CHECKSUM_EN
          sum_d        = '0;
          csum_phase_d = 1'b0;
`endif
        end
      end
      StFetch: begin
        state_d = StCapture;
      end
      StCapture: begin
        pk_capture = 1'b1;
        frame_d    = frame_q + 1'b1;
`ifdef SEQ_LOADER_CHECKSUM_EN
        sum_d = sum_q + bus.rom_q;
`endif
        if ((pk_count == COUNT_W'(FRAMES_PER_WORD - 1)) || (frame_q == LastFrame)) begin
          state_d = StWrite;
        end else begin
          state_d = StFetch;
        end
      end
      StWrite: begin
        wraddr_d = wraddr_q + 1'b1;
        pk_clear = 1'b1;
        if (frame_q == FrameEnd) begin
`ifdef SEQ_LOADER_CHECKSUM_EN
          // Stay in WRITE one more cycle to emit the checksum word.
          if (csum_phase_q) begin
            state_d = StDone;
          end else begin
            csum_phase_d = 1'b1;
            state_d      = StWrite;
          end
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ROM address is registered on entry to FETCH so the ROM sees it for the whole cycle.
  always_comb begin
    addr_full  = 16'(seq_d) * 16'(FRAMES_PER_SEQ) + 16'(frame_d);
    rom_addr_d = rom_addr_q;
    if (state_d == StFetch) begin
      rom_addr_d = addr_full[ROM_AW-1:0];
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= StIdle;
      seq_q      <= '0;
      frame_q    <= '0;
      rom_addr_q <= '0;
      wraddr_q   <= RAM_BASE;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      frame_q    <= frame_d;
      rom_addr_q <= rom_addr_d;
      wraddr_q   <= wraddr_d;
    end
  end

`ifdef SEQ_LOADER_CHECKSUM_EN
  // Running frame sum and checksum-word phase flag.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sum_q        <= '0;
      csum_phase_q <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      csum_phase_q <= csum_phase_d;
    end
  end
`endif

  // Select the word presented during WRITE.
  always_comb begin
`ifdef SEQ_LOADER_CHECKSUM_EN
    word_out = csum_phase_q ? {{(RAM_DW - SLOT_W){1'b0}}, sum_q} : pk_word;
`else
    word_out = pk_word;
`endif
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.ram_wraddress = wraddr_q;
  assign bus.ram_wren      = (state_q == StWrite);
  assign bus.ram_data      = (state_q == StWrite) ? word_out : '0;
  assign bus.busy          = (state_q == StFetch) || (state_q == StCapture) ||
                             (state_q == StWrite);
  assign bus.done          = (state_q == StDone);

endmodule

// File: tb/tb_seq_loader.sv
// Self-checking bench for seq_loader: two instances (RAM_BASE 0 and 125) share
// the request stimulus; each has a registered ROM model (rom_q = rom_addr delayed
// one clock) and its own scoreboard of expected RAM writes.
module tb_seq_loader;
  import seq_loader_pkg::*;

  localparam int Frames = 16;
`ifdef SEQ_LOADER_CHECKSUM_EN
  localparam int DoneCyc   = 40;
  localparam int NumWrites = 7;
`else
  localparam int DoneCyc   = 39;
  localparam int NumWrites = 6;
`endif

  logic clk_50 = 1'b0;
  logic reset;

  always #10 clk_50 = ~clk_50;

  seq_loader_if bus ();
  seq_loader_if bus_b ();

  assign bus_b.start   = bus.start;
  assign bus_b.seq_num = bus.seq_num;

  always @(posedge clk_50) bus.rom_q   <= bus.rom_addr;
  always @(posedge clk_50) bus_b.rom_q <= bus_b.rom_addr;

  seq_loader #(.FRAMES_PER_SEQ(16), .RAM_BASE(7'd0)) u_dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus.master)
  );

  seq_loader #(.FRAMES_PER_SEQ(16), .RAM_BASE(7'd125)) u_dut_b (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus_b.master)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [5:0] seq;
    bit         repulse;
    int         exp_done;
    logic [9:0] exp_rom0;
  } vec_t;

  wr_t exp_q[$];
  wr_t exp_qb[$];

  int checks   = 0;
  int errors   = 0;
  int writes_a = 0;
  int writes_b = 0;
  int dones_a  = 0;
  int dones_b  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [5:0] seq, input int w);
    logic [31:0] r;
    int n;
    r = '0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      int f;
      f = 3 * w + k;
      if (f < Frames) begin
        r[10*k +: 10] = 10'((int'(seq) * Frames + f) % 1024);
        n++;
      end
    end
    r[31:30] = 2'(n);
    return r;
  endfunction

  function automatic logic [31:0] model_sum(input logic [5:0] seq);
    int s;
    s = 0;
    for (int f = 0; f < Frames; f++) s += (int'(seq) * Frames + f) % 1024;
    return 32'(s % 1024);
  endfunction

  task automatic push_word(input logic [5:0] seq, input int w);
    exp_q.push_back('{addr: 7'(w), data: model_word(seq, w)});
    exp_qb.push_back('{addr: 7'(125 + w), data: model_word(seq, w)});
  endtask

  task automatic push_load(input logic [5:0] seq);
    for (int w = 0; w < 6; w++) push_word(seq, w);
`ifdef SEQ_LOADER_CHECKSUM_EN
    exp_q.push_back('{addr: 7'(6), data: model_sum(seq)});
    exp_qb.push_back('{addr: 7'(125 + 6), data: model_sum(seq)});
`endif
  endtask

  // Write/done monitors for both instances, sampled mid-cycle.
  always @(negedge clk_50) begin : mon_a
    wr_t e;
    if (bus.done) dones_a++;
    if (bus.ram_wren) begin
      writes_a++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_a addr=%0d data=%0d required=no write",
                 bus.ram_wraddress, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr_a", 32'(bus.ram_wraddress), 32'(e.addr));
        check("wr_data_a", bus.ram_data, e.data);
      end
    end
  end

  always @(negedge clk_50) begin : mon_b
    wr_t e;
    if (bus_b.done) dones_b++;
    if (bus_b.ram_wren) begin
      writes_b++;
      if (exp_qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_b addr=%0d data=%0d required=no write",
                 bus_b.ram_wraddress, bus_b.ram_data);
      end else begin
        e = exp_qb.pop_front();
        check("wr_addr_b", 32'(bus_b.ram_wraddress), 32'(e.addr));
        check("wr_data_b", bus_b.ram_data, e.data);
      end
    end
  end

  // Cycle 1 is the cycle right after the start-sampling edge; returns the cycle
  // in which done is seen. seq_num is scrambled every busy cycle.
  task automatic wait_done(input bit repulse, input logic [9:0] rom0, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk_50);
      cyc++;
      if (cyc == 1) begin
        check("busy_cycle1_a", 32'(bus.busy), 32'd1);
        check("busy_cycle1_b", 32'(bus_b.busy), 32'd1);
        check("rom_addr_cycle1", 32'(bus.rom_addr), 32'(rom0));
      end
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        bus.seq_num = 6'($urandom);
        bus.start   = repulse && (cyc == 5 || cyc == 20);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no done required=done by cycle %0d", DoneCyc);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int d0a, d0b, w0a, w0b;
    @(negedge clk_50);
    d0a = dones_a;
    d0b = dones_b;
    w0a = writes_a;
    w0b = writes_b;
    bus.seq_num = v.seq;
    bus.start   = 1'b1;
    push_load(v.seq);
    @(posedge clk_50);
    #1 bus.start = 1'b0;
    wait_done(v.repulse, v.exp_rom0, cyc);
    check("done_cycle", 32'(cyc), 32'(v.exp_done));
    @(negedge clk_50);
    check("done_pulses_a", 32'(dones_a - d0a), 32'd1);
    check("done_pulses_b", 32'(dones_b - d0b), 32'd1);
    check("write_count_a", 32'(writes_a - w0a), 32'(NumWrites));
    check("write_count_b", 32'(writes_b - w0b), 32'(NumWrites));
    check("pending_a", 32'(exp_q.size()), 32'd0);
    check("pending_b", 32'(exp_qb.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int cyc;
    int d0a, w0a;

    vecs[0] = '{seq: 6'd2,  repulse: 1'b0, exp_done: DoneCyc, exp_rom0: 10'd32};
    vecs[1] = '{seq: 6'd63, repulse: 1'b0, exp_done: DoneCyc, exp_rom0: 10'd1008};
    vecs[2] = '{seq: 6'd2,  repulse: 1'b1, exp_done: DoneCyc, exp_rom0: 10'd32};
    vecs[3] = '{seq: 6'd0,  repulse: 1'b0, exp_done: DoneCyc, exp_rom0: 10'd0};
    vecs[4] = '{seq: 6'd21, repulse: 1'b1, exp_done: DoneCyc, exp_rom0: 10'd336};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.seq_num = '0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_wraddr_a", 32'(bus.ram_wraddress), 32'd0);
    check("rst_wraddr_b", 32'(bus_b.ram_wraddress), 32'd125);
    check("rst_ram_data", bus.ram_data, 32'd0);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset at cycle 12 aborts the load after word 0 has been written.
    @(negedge clk_50);
    bus.seq_num = 6'd7;
    bus.start   = 1'b1;
    push_word(6'd7, 0);
    @(posedge clk_50);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    check("abort_busy_a", 32'(bus.busy), 32'd0);
    check("abort_wren_a", 32'(bus.ram_wren), 32'd0);
    check("abort_busy_b", 32'(bus_b.busy), 32'd0);
    check("abort_wren_b", 32'(bus_b.ram_wren), 32'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk_50);
    check("abort_pending_a", 32'(exp_q.size()), 32'd0);
    check("abort_pending_b", 32'(exp_qb.size()), 32'd0);
    run_vec('{seq: 6'd9, repulse: 1'b0, exp_done: DoneCyc, exp_rom0: 10'd144});

    // start raised in the DONE cycle is ignored, then accepted in the next IDLE cycle.
    @(negedge clk_50);
    d0a = dones_a;
    w0a = writes_a;
    bus.seq_num = 6'd4;
    bus.start   = 1'b1;
    push_load(6'd4);
    @(posedge clk_50);
    #1 bus.start = 1'b0;
    wait_done(1'b0, 10'd64, cyc);
    check("chain_done_cycle1", 32'(cyc), 32'(DoneCyc));
    bus.start   = 1'b1;
    bus.seq_num = 6'd11;
    @(negedge clk_50);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    push_load(6'd11);
    @(posedge clk_50);
    #1 bus.start = 1'b0;
    wait_done(1'b0, 10'd176, cyc);
    check("chain_done_cycle2", 32'(cyc), 32'(DoneCyc));
    @(negedge clk_50);
    check("chain_dones", 32'(dones_a - d0a), 32'd2);
    check("chain_writes", 32'(writes_a - w0a), 32'(2 * NumWrites));
    check("chain_pending_a", 32'(exp_q.size()), 32'd0);
    check("chain_pending_b", 32'(exp_qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_loader.md
SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEQ, default 16, meaning ROM frames per sequence (power of two, 4..16).
REQ-002 SHALL have parameter RAM_BASE, default 7'd0, meaning first RAM write address.
REQ-003 SHALL have port clk_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port seq_num  input  6  sequence to load.
REQ-007 SHALL have port rom_addr  output  10  ROM read address.
REQ-008 SHALL have port rom_q  input  10  ROM data, valid one clock after rom_addr.
REQ-009 SHALL have port ram_wraddress  output  7  RAM write address.
REQ-010 SHALL have port ram_data  output  32  RAM write data.
REQ-011 SHALL have port ram_wren  output  1  RAM write strobe, one cycle per word.
REQ-012 SHALL have port busy  output  1  high from the cycle after start is accepted until DONE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at completion.

Function
REQ-014 SHALL use states IDLE, FETCH, CAPTURE, WRITE, DONE.
REQ-015 IDLE SHALL, on start=1, latch seq_num, clear frame and slot counters, set wraddress to RAM_BASE, and enter FETCH.
REQ-016 FETCH SHALL drive rom_addr = seq_num*FRAMES_PER_SEQ + frame (10-bit truncated) and enter CAPTURE.
REQ-017 CAPTURE SHALL store rom_q into the current slot, then increment slot and frame.
REQ-018 CAPTURE SHALL enter WRITE when slot reaches 3 or the last frame is captured, and SHALL enter FETCH otherwise.
REQ-019 The packed word SHALL hold slot0 in [9:0], slot1 in [19:10], slot2 in [29:20], and the valid-slot count (1..3) in [31:30]; unused slots SHALL be zero.
REQ-020 WRITE SHALL assert ram_wren for exactly one cycle with ram_data and ram_wraddress stable, then increment wraddress and clear the packer.
REQ-021 WRITE SHALL enter DONE after the last frame, and FETCH otherwise.
REQ-022 DONE SHALL assert done for one cycle and return to IDLE.
REQ-023 With FRAMES_PER_SEQ=16, the block SHALL write 6 words, and done SHALL assert 39 cycles after the start-sampling edge.
REQ-024 start while busy SHALL be ignored; seq_num changes while busy SHALL have no effect.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.
REQ-026 ram_wraddress SHALL wrap modulo 128.
REQ-027 ram_wren SHALL never be asserted outside WRITE.

Reset
REQ-028 reset SHALL force IDLE and set rom_addr=0, ram_wraddress=RAM_BASE, ram_data=0, ram_wren=0, busy=0, done=0, and clear all counters.
REQ-029 reset during a load SHALL abort it with no further RAM write; reset overrides start in the same cycle.

Configuration
REQ-030 With macro SEQ_LOADER_CHECKSUM_EN defined, the block SHALL accumulate a 10-bit modulo-1024 sum of all captured frames.
REQ-031 With the macro defined, the block SHALL write one extra word {22'd0, sum} after the last data word, which adds one cycle (done at cycle 40).
REQ-032 Without the macro, no checksum logic or extra write SHALL exist.

Structure
REQ-033 Package seq_loader_pkg SHALL hold the state enum, FRAMES_PER_WORD=3, ROM_AW=10, RAM_AW=7, RAM_DW=32, and the field offsets.
REQ-034 Sub-module frame_packer SHALL implement slot storage, the slot count, word assembly and clear; the FSM and counters stay in seq_loader.

Verification (ROM model: rom_q = registered rom_addr)
REQ-035 reset, then start=1 with seq_num=2 -> rom_addr 32..47; word0 = {2'd3, 34, 33, 32} at address 0; word5 = {2'd1, 0, 0, 47} at address 5; done at cycle 39.
REQ-036 start=1 with seq_num=63 -> rom_addr 1008..1023, no overflow; 6 writes.
REQ-037 start re-pulsed at cycles 5 and 20 of a load -> ignored; exactly 6 writes and one done.
REQ-038 reset asserted at cycle 12 -> busy=0 and ram_wren=0 on the next cycle; no further writes; a new start then completes normally.
REQ-039 RAM_BASE=7'd125 -> words written at 125, 126, 127, 0, 1, 2.
REQ-040 with SEQ_LOADER_CHECKSUM_EN and seq_num=2 -> 7th word at address 6 = 632; done at cycle 40.
